fast_uart: RTL and testbench
============================

// Module: fast_uart
// PURPOSE
//  Full-duplex 8N1 UART: one byte transmitter and one byte receiver, both timed by one integer divider.
//  Runs as the host-side serial peer of the SoC user-space UART in simulation, and as a general peripheral.
//  Built for high baud/clock ratios: down to 4 clocks per bit, with no oversampling.
// PARAMETERS
//  CLK_FREQ      40000000  clock frequency in Hz
//  BAUD          9216000   line rate in bit/s
//  CLKS_PER_BIT  derived   (CLK_FREQ + BAUD/2) / BAUD, rounded; 4 at the defaults. Elaboration error if < 4.
// PORTS
//  clk              in   1  single clock; all logic is posedge
//  rst              in   1  asynchronous, active-low reset (port keeps the codebase name rst)
//  txEnable         in   1  request to send txData; sampled on the clock edge
//  txData           in   8  byte to transmit; captured when the request is accepted
//  txBusy           out  1  transmitter is occupied
//  rxDataAvailable  out  1  one-cycle strobe: rxData holds a new byte
//  rxData           out  8  last byte received
//  rx               in   1  serial input; idles high (external pullup)
//  tx               out  1  serial output; idles high
// BEHAVIOUR
//  Reset values: tx=1, txBusy=0, rxDataAvailable=0, rxData=0. Both state machines go to IDLE and counters clear.
//  Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Every bit lasts CLKS_PER_BIT cycles.
//  TX states: IDLE -> START -> DATA(8 bits) -> STOP -> IDLE.
//   - A request is accepted when txEnable=1 in IDLE. On that edge, txData is latched, txBusy goes to 1,
//     and tx goes low on the next cycle.
//   - txEnable while txBusy=1 is ignored; no queueing.
//   - txBusy stays 1 through the whole stop bit and clears on the cycle tx returns to idle.
//   - Back-to-back frames: holding txEnable=1 sends the next frame on the first IDLE cycle.
//     The minimum gap is 1 idle cycle.
//  RX states: IDLE -> START -> DATA -> STOP -> IDLE.
//   - rx passes through a 2-flop synchroniser, initialised to 1.
//   - A synchronised high-to-low edge in IDLE starts a frame.
//   - START: wait CLKS_PER_BIT/2 cycles, then re-sample. If rx is high, treat it as a glitch and return to IDLE.
//   - DATA: sample each bit at its centre, CLKS_PER_BIT cycles apart, shifting in LSB first.
//   - STOP: sample at the centre.
//     - Stop=1: rxData updates and rxDataAvailable=1 for exactly one cycle. Then return to IDLE,
//       ready for a new start edge in the same half bit.
//     - Stop=0 (framing error): byte discarded, no strobe, rxData unchanged. Wait for rx high before re-arming.
//   - rxData holds its value until the next valid frame.
//  TX and RX are fully independent. Simultaneous transmit and receive is required (full duplex).
//  Reset asserted mid-frame: both sides abort at once. tx is forced high. The partial byte is never strobed.
//  Counters are sized $clog2(CLKS_PER_BIT)+1 bits. The bit index is 3 bits and wraps 7 -> done.
// STRUCTURE
//  Shared package fast_uart_pkg: state enums for the TX and RX FSMs, and a function computing CLKS_PER_BIT.
//  One sub-module: fast_uart_rx (synchroniser + RX FSM). The TX path is small and stays in fast_uart.
// TESTING
//  Loopback (defaults, CLKS_PER_BIT=4):
//   - Stimulus: tx tied to rx; pulse txEnable with 8'h48 'H'.
//   - Response: txBusy high for 40 cycles; rxDataAvailable pulses once, about 40 cycles later; rxData=8'h48.
//  Waveform:
//   - Stimulus: send 8'hA5.
//   - Response: tx reads 0,1,0,1,0,0,1,0,1,1, each level held exactly 4 cycles.
//  Busy ignore:
//   - Stimulus: txEnable=1 with 8'h73 's'; 10 cycles later txEnable=1 with 8'h61.
//   - Response: only 8'h73 appears on the line.
//  Receive sequence:
//   - Stimulus: bench drives "Hello" on rx at 4 clocks/bit.
//   - Response: five strobes with 48,65,6C,6C,6F in order.
//  Glitch and framing error:
//   - Stimulus: a 1-cycle low pulse on rx, then a frame with stop=0.
//   - Response: no strobe for either; a following valid 8'h77 'w' is received.
//  Async reset:
//   - Stimulus: drop rst mid-TX at bit 3.
//   - Response: tx=1 and txBusy=0 at once; after release, a new send works.

Source files
------------

// File: rtl/fast_uart_pkg.sv
// Shared types and helpers for the fast_uart transmitter and receiver.
// Bit timing is one integer divider with no oversampling.
package fast_uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } txState_t;

    // RX_RECOVER holds off re-arming after a framing error until the line is high again.
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_RECOVER
    } rxState_t;

    localparam int MIN_CLKS_PER_BIT = 4;

    // Clocks per bit, rounded to the nearest integer.
    function automatic int clksPerBit(input int clkFreq, input int baud);
        return (clkFreq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/fast_uart_rx.sv
// 8N1 receiver: 2-flop synchroniser, start-edge detect, centre sampling of every bit.
// rxDataAvailable is a one-cycle strobe; rxData holds until the next good frame.
module fast_uart_rx
    import fast_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rxData,
    output logic       rxDataAvailable
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rxMeta;
    logic             rxSync;
    logic             rxPrev;
    rxState_t         rxState;
    rxState_t         rxStateNext;
    logic [CNT_W-1:0] rxCnt;
    logic [2:0]       bitIdx;
    logic [7:0]       rxShift;
    logic             cntClear;
    logic             shiftEn;
    logic             byteDone;

    // Synchroniser and edge history start high so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
            rxPrev <= 1'b1;
        end else begin
            rxMeta <= rx;
            rxSync <= rxMeta;
            rxPrev <= rxSync;
        end
    end

    always_comb begin
        rxStateNext = rxState;
        cntClear    = 1'b0;
        shiftEn     = 1'b0;
        byteDone    = 1'b0;
        case (rxState)
            RX_IDLE: begin
                cntClear = 1'b1;
                if (rxPrev && !rxSync) rxStateNext = RX_START;
            end
            RX_START: begin
                // The first low sample is bit position 0, so counting HALF cycles lands mid-bit.
                if (rxCnt == HALF_LAST) begin
                    cntClear    = 1'b1;
                    rxStateNext = rxSync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rxCnt == BIT_LAST) begin
                    cntClear = 1'b1;
                    shiftEn  = 1'b1;
                    if (bitIdx == 3'd7) rxStateNext = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rxCnt == BIT_LAST) begin
                    cntClear = 1'b1;
                    if (rxSync) begin
                        byteDone    = 1'b1;
                        rxStateNext = RX_IDLE;
                    end else begin
                        rxStateNext = RX_RECOVER;
                    end
                end
            end
            RX_RECOVER: begin
                cntClear = 1'b1;
                if (rxSync) rxStateNext = RX_IDLE;
            end
            default: rxStateNext = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxState         <= RX_IDLE;
            rxCnt           <= '0;
            bitIdx          <= 3'd0;
            rxShift         <= 8'h00;
            rxData          <= 8'h00;
            rxDataAvailable <= 1'b0;
        end else begin
            rxState         <= rxStateNext;
            rxCnt           <= cntClear ? '0 : rxCnt + 1'b1;
            rxDataAvailable <= byteDone;
            if (rxState == RX_IDLE) begin
                bitIdx <= 3'd0;
            end else if (shiftEn) begin
                bitIdx <= bitIdx + 3'd1;
            end
            if (shiftEn) rxShift <= {rxSync, rxShift[7:1]};
            if (byteDone) rxData <= rxShift;
        end
    end

endmodule

// File: rtl/fast_uart.sv
// Full-duplex 8N1 UART: transmitter here, receiver in fast_uart_rx, both on one integer divider.
// Handshake: a send is accepted on any edge with txEnable=1 while the transmitter is idle; txBusy covers the whole frame.
module fast_uart
    import fast_uart_pkg::*;
#(
    parameter int CLK_FREQ = 40000000,
    parameter int BAUD     = 9216000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       txEnable,
    input  logic [7:0] txData,
    output logic       txBusy,
    output logic       rxDataAvailable,
    output logic [7:0] rxData,
    input  logic       rx,
    output logic       tx
);

    localparam int CLKS_PER_BIT = clksPerBit(CLK_FREQ, BAUD);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : gBadRatio
            $error("fast_uart: CLK_FREQ/BAUD gives fewer than 4 clocks per bit");
        end
    endgenerate

    txState_t         txState;
    txState_t         txStateNext;
    logic [CNT_W-1:0] txCnt;
    logic [2:0]       txBitIdx;
    logic [7:0]       txShift;
    logic [7:0]       txShiftNext;
    logic             txLineNext;
    logic             txBusyNext;
    logic             bitDone;

    assign bitDone = (txCnt == BIT_LAST);

    always_comb begin
        txStateNext = txState;
        txShiftNext = txShift;
        case (txState)
            TX_IDLE: begin
                if (txEnable) begin
                    txStateNext = TX_START;
                    txShiftNext = txData;
                end
            end
            TX_START: begin
                if (bitDone) txStateNext = TX_DATA;
            end
            TX_DATA: begin
                if (bitDone) begin
                    txShiftNext = {1'b0, txShift[7:1]};
                    if (txBitIdx == 3'd7) txStateNext = TX_STOP;
                end
            end
            TX_STOP: begin
                if (bitDone) txStateNext = TX_IDLE;
            end
            default: txStateNext = TX_IDLE;
        endcase

        // tx and txBusy are registered from the next state so the line never glitches.
        case (txStateNext)
            TX_START: txLineNext = 1'b0;
            TX_DATA:  txLineNext = txShiftNext[0];
            default:  txLineNext = 1'b1;
        endcase
        txBusyNext = (txStateNext != TX_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txState  <= TX_IDLE;
            txCnt    <= '0;
            txBitIdx <= 3'd0;
            txShift  <= 8'h00;
            tx       <= 1'b1;
            txBusy   <= 1'b0;
        end else begin
            txState <= txStateNext;
            txShift <= txShiftNext;
            tx      <= txLineNext;
            txBusy  <= txBusyNext;
            if (txState == TX_IDLE || bitDone) begin
                txCnt <= '0;
            end else begin
                txCnt <= txCnt + 1'b1;
            end
            if (txState == TX_IDLE) begin
                txBitIdx <= 3'd0;
            end else if (txState == TX_DATA && bitDone) begin
                txBitIdx <= txBitIdx + 3'd1;
            end
        end
    end

    fast_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) uRx (
        .clk            (clk),
        .rst            (rst),
        .rx             (rx),
        .rxData         (rxData),
        .rxDataAvailable(rxDataAvailable)
    );

endmodule

// File: tb/tb_fast_uart.sv
// Directed bench for fast_uart at the default 4 clocks per bit.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fast_uart;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_enable = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_busy;
  logic       rx_avail;
  logic [7:0] rx_data;
  logic       tx;
  logic       rx_drive = 1'b1;
  logic       loopback = 1'b0;
  logic       rx_line;

  int checks = 0;
  int failures = 0;
  int strobes = 0;
  logic [7:0] exp_q[$];

  assign rx_line = loopback ? tx : rx_drive;

  always #5 clk = ~clk;

  fast_uart #(
    .CLK_FREQ(40000000),
    .BAUD    (9216000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .txEnable       (tx_enable),
    .txData         (tx_data),
    .txBusy         (tx_busy),
    .rxDataAvailable(rx_avail),
    .rxData         (rx_data),
    .rx             (rx_line),
    .tx             (tx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst && rx_avail) begin
      strobes++;
      if (exp_q.size() == 0) check("strobe_expected", 32'(0), 32'(1));
      else check("rx_byte", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
    end
  end

  task automatic send_tx(input logic [7:0] d);
    @(negedge clk);
    tx_enable = 1'b1;
    tx_data   = d;
    @(negedge clk);
    tx_enable = 1'b0;
  endtask

  task automatic wait_tx_idle(input string tag);
    int n = 0;
    while (tx_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, {31'h0, tx_busy}, 32'(0));
  endtask

  // Drives one frame on rx starting at the current falling edge, 4 clocks per bit.
  task automatic drive_frame(input logic [7:0] d, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx_drive = f[b];
      repeat (4) @(negedge clk);
    end
    rx_drive = 1'b1;
  endtask

  initial begin
    int n;
    int base;
    logic [3:0] lv;
    logic [9:0] frame;
    logic [7:0] hello [5];

    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx", {31'h0, tx}, 32'(1));
    check("rst_busy", {31'h0, tx_busy}, 32'(0));
    check("rst_avail", {31'h0, rx_avail}, 32'(0));
    check("rst_rxdata", {24'h0, rx_data}, 32'(0));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback 'H'
    loopback = 1'b1;
    base = strobes;
    exp_q.push_back(8'h48);
    send_tx(8'h48);
    n = 0;
    while (tx_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("lb_busy_cycles", 32'(n), 32'(40));
    repeat (20) @(negedge clk);
    check("lb_strobes", 32'(strobes - base), 32'(1));
    check("lb_pending", 32'(exp_q.size()), 32'(0));

    // Waveform of 8'hA5, also looped back
    base = strobes;
    exp_q.push_back(8'hA5);
    frame = {1'b1, 8'hA5, 1'b0};
    send_tx(8'hA5);
    for (int b = 0; b < 10; b++) begin
      for (int s = 0; s < 4; s++) begin
        lv[s] = tx;
        @(negedge clk);
      end
      check($sformatf("wave_bit%0d", b), {28'h0, lv}, frame[b] ? 32'hF : 32'h0);
    end
    check("wave_end_tx", {31'h0, tx}, 32'(1));
    check("wave_end_busy", {31'h0, tx_busy}, 32'(0));
    repeat (20) @(negedge clk);
    check("wave_strobes", 32'(strobes - base), 32'(1));

    // Request while busy is ignored
    base = strobes;
    exp_q.push_back(8'h73);
    send_tx(8'h73);
    repeat (8) @(negedge clk);
    send_tx(8'h61);
    wait_tx_idle("ign");
    repeat (3) @(negedge clk);
    check("ign_busy_after", {31'h0, tx_busy}, 32'(0));
    repeat (20) @(negedge clk);
    check("ign_strobes", 32'(strobes - base), 32'(1));
    check("ign_pending", 32'(exp_q.size()), 32'(0));

    // Full duplex: independent transmit and receive at the same time
    loopback = 1'b0;
    base = strobes;
    exp_q.push_back(8'hC3);
    fork
      begin
        send_tx(8'h5A);
        wait_tx_idle("fd");
      end
      drive_frame(8'hC3, 1'b1);
    join
    repeat (10) @(negedge clk);
    check("fd_strobes", 32'(strobes - base), 32'(1));

    // Receive "Hello"
    base = strobes;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(hello[i]);
      drive_frame(hello[i], 1'b1);
    end
    repeat (10) @(negedge clk);
    check("hello_strobes", 32'(strobes - base), 32'(5));
    check("hello_pending", 32'(exp_q.size()), 32'(0));
    check("hello_hold", {24'h0, rx_data}, 32'h6F);

    // Glitch, then framing error, then a good 'w'
    base = strobes;
    rx_drive = 1'b0;
    @(negedge clk);
    rx_drive = 1'b1;
    repeat (12) @(negedge clk);
    drive_frame(8'h3C, 1'b0);
    repeat (12) @(negedge clk);
    check("bad_no_strobe", 32'(strobes - base), 32'(0));
    check("bad_rxdata_kept", {24'h0, rx_data}, 32'h6F);
    exp_q.push_back(8'h77);
    drive_frame(8'h77, 1'b1);
    repeat (10) @(negedge clk);
    check("w_strobes", 32'(strobes - base), 32'(1));
    check("w_pending", 32'(exp_q.size()), 32'(0));

    // Asynchronous reset in the middle of bit 3 of 8'h55
    loopback = 1'b1;
    base = strobes;
    send_tx(8'h55);
    repeat (17) @(negedge clk);
    check("pre_rst_tx", {31'h0, tx}, 32'(0));
    #2 rst = 1'b0;
    #1;
    check("arst_tx", {31'h0, tx}, 32'(1));
    check("arst_busy", {31'h0, tx_busy}, 32'(0));
    check("arst_avail", {31'h0, rx_avail}, 32'(0));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.push_back(8'h21);
    send_tx(8'h21);
    check("post_rst_busy", {31'h0, tx_busy}, 32'(1));
    wait_tx_idle("post_rst");
    repeat (20) @(negedge clk);
    check("post_rst_strobes", 32'(strobes - base), 32'(1));
    check("post_rst_pending", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
